// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the tile DMEM arbiter.
package dmem_arbiter_pkg;

  localparam int unsigned dmem_lanes_gp      = 4;
  localparam int unsigned data_width_gp      = 32;
  localparam int unsigned data_mask_width_gp = data_width_gp >> 3;
  localparam int unsigned dmem_size_gp       = 1024;

  // clog2 that never returns zero, so one-entry ranges still get a 1-bit field
  function automatic int unsigned safe_clog2(input int unsigned value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

  localparam int unsigned dmem_addr_width_gp = safe_clog2(dmem_size_gp);

  // One DMEM row access: write flag, row address, four lanes of data and byte mask
  typedef struct packed {
    logic                                                w;
    logic [dmem_addr_width_gp-1:0]                       addr;
    logic [dmem_lanes_gp-1:0][data_width_gp-1:0]         data;
    logic [dmem_lanes_gp-1:0][data_mask_width_gp-1:0]    mask;
  } dmem_req_s;

  // Place a single-word byte mask into the selected lane; all other lanes zero
  function automatic logic [dmem_lanes_gp*data_mask_width_gp-1:0] expand_lane_mask(
    input logic [data_mask_width_gp-1:0] mask,
    input logic [1:0]                    lane
  );
    logic [dmem_lanes_gp*data_mask_width_gp-1:0] full;
    full = '0;
    for (int unsigned i = 0; i < dmem_lanes_gp; i++) begin
      if (lane == 2'(i)) begin
        full[i*data_mask_width_gp +: data_mask_width_gp] = mask;
      end
    end
    return full;
  endfunction

endpackage

// File: rtl/dmem_arbiter_starve_ctr.sv
// Counts consecutive cycles the network loses arbitration and forces its grant at the limit.
module dmem_arbiter_starve_ctr
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned starve_limit_p = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic net_v_i,
  input  logic net_yumi_i,
  output logic force_net_c_o
);

  localparam int unsigned cnt_width_lp = safe_clog2(starve_limit_p + 1);
  localparam logic [cnt_width_lp-1:0] limit_lp = cnt_width_lp'(starve_limit_p);

  logic [cnt_width_lp-1:0] cnt_q, cnt_d;

  // Force the network through once it has waited the full limit
  assign force_net_c_o = net_v_i & (cnt_q == limit_lp);

  // Clear on a network grant, count up saturating while it waits, hold when idle
  always_comb begin
    cnt_d = cnt_q;
    if (net_yumi_i) begin
      cnt_d = '0;
    end else if (net_v_i && (cnt_q != limit_lp)) begin
      cnt_d = cnt_q + cnt_width_lp'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported tile DMEM between the core LSU and the network endpoint,
// tracks read-data ownership, and holds the load-reserved reservation.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned data_width_p   = data_width_gp,
  parameter int unsigned dmem_size_p    = dmem_size_gp,
  parameter int unsigned starve_limit_p = 4
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,

  input  logic                                  core_v_i,
  input  logic                                  core_w_i,
  input  logic [safe_clog2(dmem_size_p)-1:0]    core_addr_i,
  input  logic [4*data_width_p-1:0]             core_data_i,
  input  logic [4*(data_width_p>>3)-1:0]        core_mask_i,
  input  logic                                  core_reserve_i,
  input  logic                                  core_reserve_clear_i,
  output logic                                  core_yumi_o,
  output logic                                  core_rdata_v_o,

  input  logic                                  net_v_i,
  input  logic                                  net_w_i,
  input  logic [safe_clog2(dmem_size_p)-1:0]    net_addr_i,
  input  logic [1:0]                            net_lane_i,
  input  logic [data_width_p-1:0]               net_data_i,
  input  logic [(data_width_p>>3)-1:0]          net_mask_i,
  output logic                                  net_yumi_o,
  output logic                                  net_resp_v_o,
  output logic                                  net_resp_w_o,

  output logic                                  dmem_v_o,
  output logic                                  dmem_w_o,
  output logic [safe_clog2(dmem_size_p)-1:0]    dmem_addr_o,
  output logic [4*data_width_p-1:0]             dmem_data_o,
  output logic [4*(data_width_p>>3)-1:0]        dmem_mask_o,

  output logic                                  reserved_o,
  output logic [safe_clog2(dmem_size_p)-1:0]    reserved_addr_o
);

  localparam int unsigned dmem_addr_width_lp = safe_clog2(dmem_size_p);

  logic force_net;
  dmem_req_s core_req, net_req, win_req;

  logic core_rdata_v_q, core_rdata_v_d;
  logic net_resp_v_q, net_resp_v_d;
  logic net_resp_w_q, net_resp_w_d;
  logic resv_v_q, resv_v_d;
  logic [dmem_addr_width_lp-1:0] resv_addr_q, resv_addr_d;

  dmem_arbiter_starve_ctr #(
    .starve_limit_p(starve_limit_p)
  ) starve_ctr (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .net_v_i      (net_v_i),
    .net_yumi_i   (net_yumi_o),
    .force_net_c_o(force_net)
  );

  // Core has fixed priority unless the network has starved
  assign core_yumi_o = core_v_i & ~force_net;
  assign net_yumi_o  = net_v_i & (~core_v_i | force_net);

  // Build both candidate row requests; network word goes to every lane, mask to one lane
  always_comb begin
    core_req      = '0;
    core_req.w    = core_w_i;
    core_req.addr = core_addr_i;
    core_req.data = core_data_i;
    core_req.mask = core_mask_i;

    net_req       = '0;
    net_req.w     = net_w_i;
    net_req.addr  = net_addr_i;
    net_req.data  = {4{net_data_i}};
    net_req.mask  = expand_lane_mask(net_mask_i, net_lane_i);
  end

  // Winner mux; idle cycles present the core side
  assign win_req     = net_yumi_o ? net_req : core_req;
  assign dmem_v_o    = core_yumi_o | net_yumi_o;
  assign dmem_w_o    = win_req.w;
  assign dmem_addr_o = win_req.addr;
  assign dmem_data_o = win_req.data;
  assign dmem_mask_o = win_req.mask;

  // Next-state for response ownership flags and the reservation
  always_comb begin
    logic resv_set;
    logic resv_hit;

    core_rdata_v_d = core_yumi_o & ~core_w_i;
    net_resp_v_d   = net_yumi_o;
    net_resp_w_d   = net_yumi_o & net_w_i;

    resv_set = core_yumi_o & ~core_w_i & core_reserve_i;
    resv_hit = resv_v_q & dmem_v_o & win_req.w
             & (win_req.addr == resv_addr_q) & (|win_req.mask);

    resv_v_d    = resv_v_q;
    resv_addr_d = resv_addr_q;
    if (resv_set) begin
      resv_v_d    = 1'b1;
      resv_addr_d = core_addr_i;
    end else if (resv_hit || core_reserve_clear_i) begin
      resv_v_d    = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      core_rdata_v_q <= 1'b0;
      net_resp_v_q   <= 1'b0;
      net_resp_w_q   <= 1'b0;
      resv_v_q       <= 1'b0;
      resv_addr_q    <= '0;
    end else begin
      core_rdata_v_q <= core_rdata_v_d;
      net_resp_v_q   <= net_resp_v_d;
      net_resp_w_q   <= net_resp_w_d;
      resv_v_q       <= resv_v_d;
      resv_addr_q    <= resv_addr_d;
    end
  end

  assign core_rdata_v_o  = core_rdata_v_q;
  assign net_resp_v_o    = net_resp_v_q;
  assign net_resp_w_o    = net_resp_w_q;
  assign reserved_o      = resv_v_q;
  assign reserved_addr_o = resv_addr_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: arbitration, starvation, lane muxing, responses, reservation, reset.
module tb_dmem_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned MW = DW >> 3;
  localparam int unsigned AW = 10;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              core_v_i, core_w_i, core_reserve_i, core_reserve_clear_i;
  logic [AW-1:0]     core_addr_i;
  logic [4*DW-1:0]   core_data_i;
  logic [4*MW-1:0]   core_mask_i;
  logic              core_yumi_o, core_rdata_v_o;
  logic              net_v_i, net_w_i;
  logic [AW-1:0]     net_addr_i;
  logic [1:0]        net_lane_i;
  logic [DW-1:0]     net_data_i;
  logic [MW-1:0]     net_mask_i;
  logic              net_yumi_o, net_resp_v_o, net_resp_w_o;
  logic              dmem_v_o, dmem_w_o;
  logic [AW-1:0]     dmem_addr_o;
  logic [4*DW-1:0]   dmem_data_o;
  logic [4*MW-1:0]   dmem_mask_o;
  logic              reserved_o;
  logic [AW-1:0]     reserved_addr_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  dmem_arbiter #(.data_width_p(32), .dmem_size_p(1024), .starve_limit_p(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .core_v_i(core_v_i), .core_w_i(core_w_i), .core_addr_i(core_addr_i),
    .core_data_i(core_data_i), .core_mask_i(core_mask_i),
    .core_reserve_i(core_reserve_i), .core_reserve_clear_i(core_reserve_clear_i),
    .core_yumi_o(core_yumi_o), .core_rdata_v_o(core_rdata_v_o),
    .net_v_i(net_v_i), .net_w_i(net_w_i), .net_addr_i(net_addr_i),
    .net_lane_i(net_lane_i), .net_data_i(net_data_i), .net_mask_i(net_mask_i),
    .net_yumi_o(net_yumi_o), .net_resp_v_o(net_resp_v_o), .net_resp_w_o(net_resp_w_o),
    .dmem_v_o(dmem_v_o), .dmem_w_o(dmem_w_o), .dmem_addr_o(dmem_addr_o),
    .dmem_data_o(dmem_data_o), .dmem_mask_o(dmem_mask_o),
    .reserved_o(reserved_o), .reserved_addr_o(reserved_addr_o)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    core_v_i = 0; core_w_i = 0; core_addr_i = '0; core_data_i = '0; core_mask_i = '0;
    core_reserve_i = 0; core_reserve_clear_i = 0;
    net_v_i = 0; net_w_i = 0; net_addr_i = '0; net_lane_i = '0; net_data_i = '0; net_mask_i = '0;
  endtask

  initial begin
    logic exp_net;

    // ---- reset ----
    reset_i = 1'b1;
    idle_inputs();
    step(); step();
    #2 reset_i = 1'b0;
    #1;
    chk("rst_reserved", 128'(reserved_o), 128'(0));
    chk("rst_resv_addr", 128'(reserved_addr_o), 128'(0));
    chk("rst_core_rdata_v", 128'(core_rdata_v_o), 128'(0));
    chk("rst_net_resp_v", 128'(net_resp_v_o), 128'(0));
    chk("rst_net_resp_w", 128'(net_resp_w_o), 128'(0));
    chk("idle_core_yumi", 128'(core_yumi_o), 128'(0));
    chk("idle_net_yumi", 128'(net_yumi_o), 128'(0));
    chk("idle_dmem_v", 128'(dmem_v_o), 128'(0));

    // ---- core read at 0x10 ----
    step();
    core_v_i = 1; core_w_i = 0; core_addr_i = 10'h010;
    #1;
    chk("rd_core_yumi", 128'(core_yumi_o), 128'(1));
    chk("rd_dmem_v", 128'(dmem_v_o), 128'(1));
    chk("rd_dmem_w", 128'(dmem_w_o), 128'(0));
    chk("rd_dmem_addr", 128'(dmem_addr_o), 128'(10'h010));
    step();
    idle_inputs();
    chk("rd_rdata_v_c1", 128'(core_rdata_v_o), 128'(1));
    step();
    chk("rd_rdata_v_c2", 128'(core_rdata_v_o), 128'(0));

    // ---- continuous contention: net wins every 5th cycle ----
    core_v_i = 1; core_w_i = 0; core_addr_i = 10'h001;
    net_v_i = 1; net_w_i = 0; net_addr_i = 10'h002;
    for (int c = 0; c < 15; c++) begin
      exp_net = ((c % 5) == 4);
      #1;
      chk($sformatf("starve_net_yumi_c%0d", c), 128'(net_yumi_o), 128'(exp_net));
      chk($sformatf("starve_core_yumi_c%0d", c), 128'(core_yumi_o), 128'(!exp_net));
      step();
      chk($sformatf("starve_net_resp_c%0d", c), 128'(net_resp_v_o), 128'(exp_net));
      chk($sformatf("starve_core_rdv_c%0d", c), 128'(core_rdata_v_o), 128'(!exp_net));
    end
    idle_inputs();
    step();

    // ---- network write lane 2, mask 0011 ----
    net_v_i = 1; net_w_i = 1; net_addr_i = 10'h033; net_lane_i = 2'd2;
    net_mask_i = 4'b0011; net_data_i = 32'hDEADBEEF;
    #1;
    chk("nw_net_yumi", 128'(net_yumi_o), 128'(1));
    chk("nw_dmem_w", 128'(dmem_w_o), 128'(1));
    chk("nw_dmem_addr", 128'(dmem_addr_o), 128'(10'h033));
    chk("nw_dmem_mask", 128'(dmem_mask_o), 128'(16'h0300));
    chk("nw_dmem_data", 128'(dmem_data_o), 128'h DEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);
    step();
    idle_inputs();
    chk("nw_resp_v", 128'(net_resp_v_o), 128'(1));
    chk("nw_resp_w", 128'(net_resp_w_o), 128'(1));

    // ---- LR at 0x20 and write-based clearing ----
    core_v_i = 1; core_w_i = 0; core_reserve_i = 1; core_addr_i = 10'h020;
    step();
    idle_inputs();
    chk("lr_reserved", 128'(reserved_o), 128'(1));
    chk("lr_resv_addr", 128'(reserved_addr_o), 128'(10'h020));
    net_v_i = 1; net_w_i = 1; net_addr_i = 10'h021; net_mask_i = 4'hF; net_lane_i = 2'd1;
    step();
    idle_inputs();
    chk("lr_other_addr_held", 128'(reserved_o), 128'(1));
    net_v_i = 1; net_w_i = 1; net_addr_i = 10'h020; net_mask_i = 4'h0; net_lane_i = 2'd0;
    step();
    idle_inputs();
    chk("lr_mask0_held", 128'(reserved_o), 128'(1));
    net_v_i = 1; net_w_i = 1; net_addr_i = 10'h020; net_mask_i = 4'hF; net_lane_i = 2'd0;
    step();
    idle_inputs();
    chk("lr_write_cleared", 128'(reserved_o), 128'(0));

    // ---- LR and explicit clear in the same cycle: set wins ----
    core_v_i = 1; core_w_i = 0; core_reserve_i = 1; core_addr_i = 10'h044;
    core_reserve_clear_i = 1;
    step();
    idle_inputs();
    chk("setclr_reserved", 128'(reserved_o), 128'(1));
    chk("setclr_resv_addr", 128'(reserved_addr_o), 128'(10'h044));
    core_reserve_clear_i = 1;
    step();
    idle_inputs();
    chk("clr_only_reserved", 128'(reserved_o), 128'(0));

    // ---- async reset right after a granted LR read, with net waiting ----
    core_v_i = 1; core_w_i = 0; core_reserve_i = 1; core_addr_i = 10'h055;
    net_v_i = 1; net_w_i = 0;
    step();
    idle_inputs();
    chk("mid_rdata_v_pre", 128'(core_rdata_v_o), 128'(1));
    chk("mid_reserved_pre", 128'(reserved_o), 128'(1));
    reset_i = 1'b1;
    #1;
    chk("mid_rdata_v_drop", 128'(core_rdata_v_o), 128'(0));
    chk("mid_reserved_drop", 128'(reserved_o), 128'(0));
    step();
    #2 reset_i = 1'b0;
    #1;
    chk("post_reserved", 128'(reserved_o), 128'(0));
    chk("post_resv_addr", 128'(reserved_addr_o), 128'(0));
    step();
    // Counter zero: net must lose exactly four cycles before winning
    core_v_i = 1; core_w_i = 0; core_addr_i = 10'h003;
    net_v_i = 1; net_w_i = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("post_net_yumi_c%0d", c), 128'(net_yumi_o), 128'(c == 4));
      step();
    end
    idle_inputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
